// File: rtl/fetch_ctrl_if.sv
// Bus bundle between the fetch controller and its environment
// (decode handshake, redirect, memory port, instruction output).
interface fetch_ctrl_if;
    logic        rdy_in;
    logic        stall_in;
    logic        jump_en_in;
    logic [31:0] jump_addr_in;
    logic        mem_grant_in;
    logic [7:0]  mem_din_in;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic [31:0] inst_pc_out;

    // Environment side: drives control, memory return and decode handshake
    modport master (
        output rdy_in, stall_in, jump_en_in, jump_addr_in, mem_grant_in, mem_din_in,
        input  mem_req_out, mem_addr_out, inst_valid_out, inst_out, inst_pc_out
    );

    // Fetch controller side
    modport slave (
        input  rdy_in, stall_in, jump_en_in, jump_addr_in, mem_grant_in, mem_din_in,
        output mem_req_out, mem_addr_out, inst_valid_out, inst_out, inst_pc_out
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: assembles a 32-bit little-endian word from
// four byte-wide memory accesses and holds it until decode consumes it.
// Optional feature macro: ICACHE_EN adds a 16-entry direct-mapped I-cache.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic         clk_in,
    input  logic         rst_in,
    fetch_ctrl_if.slave  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] WORD_BYTES = CNT_W'(4);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   inst_q, inst_d;
    logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;
    logic              pending_q, pending_d;
    logic [1:0]        pending_lane_q, pending_lane_d;
    logic              byte_held_q, byte_held_d;
    logic              mem_req_q, mem_req_d;
    logic              inst_valid_q, inst_valid_d;
    logic              grant_ok;
    logic              consume;

    assign grant_ok = mem_req_q & bus.rdy_in & bus.mem_grant_in;
    assign consume  = inst_valid_q & ~bus.stall_in;

`ifdef ICACHE_EN
    localparam int unsigned LINES = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned TAG_W = 26;

    logic [XLEN-1:0]  cache_data_q [LINES];
    logic [TAG_W-1:0] cache_tag_q  [LINES];
    logic [LINES-1:0] cache_vld_q, cache_vld_d;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic             cache_hit;
    logic             cache_we;

    assign pc_idx    = pc_q[5:2];
    assign pc_tag    = pc_q[31:6];
    assign cache_hit = cache_vld_q[pc_idx] && (cache_tag_q[pc_idx] == pc_tag);

    // Mark a line valid when a fetch completes into it
    always_comb begin
        cache_vld_d = cache_vld_q;
        if (cache_we) cache_vld_d[pc_idx] = 1'b1;
    end

    // Valid bits are the only cache state that needs reset
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) cache_vld_q <= '0;
        else         cache_vld_q <= cache_vld_d;
    end

    // Data and tag arrays, written with the freshly assembled word
    always_ff @(posedge clk_in) begin
        if (cache_we) begin
            cache_data_q[pc_idx] <= inst_d;
            cache_tag_q[pc_idx]  <= pc_tag;
        end
    end
`endif

    // Next-state logic: byte capture, issue counting, FSM and redirect
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        mem_addr_d     = mem_addr_q;
        inst_d         = inst_q;
        inst_pc_d      = inst_pc_q;
        issue_cnt_d    = issue_cnt_q;
        recv_cnt_d     = recv_cnt_q;
        pending_d      = pending_q;
        pending_lane_d = pending_lane_q;
        byte_held_d    = byte_held_q;
        mem_req_d      = mem_req_q;
        inst_valid_d   = inst_valid_q;
`ifdef ICACHE_EN
        cache_we       = 1'b0;
`endif
        if (!bus.rdy_in) begin
            // Frozen: the in-flight byte cannot be re-requested, so park it
            // in its lane now and account for it once rdy returns.
            if (pending_q && !byte_held_q) begin
                inst_d[{pending_lane_q, 3'b000} +: 8] = bus.mem_din_in;
                byte_held_d = 1'b1;
            end
        end else begin
            pending_d   = 1'b0;
            byte_held_d = 1'b0;
            if (pending_q) begin
                if (!byte_held_q) inst_d[{pending_lane_q, 3'b000} +: 8] = bus.mem_din_in;
                recv_cnt_d = recv_cnt_q + CNT_W'(1);
            end
            if (grant_ok) begin
                issue_cnt_d    = issue_cnt_q + CNT_W'(1);
                pending_d      = 1'b1;
                pending_lane_d = issue_cnt_q[1:0];
            end

            case (state_q)
                IDLE: begin
`ifdef ICACHE_EN
                    if (cache_hit) begin
                        inst_d       = cache_data_q[pc_idx];
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = HOLD;
                    end else
`endif
                    begin
                        issue_cnt_d = '0;
                        recv_cnt_d  = '0;
                        state_d     = FETCH;
                    end
                end
                FETCH: begin
                    if (recv_cnt_d == WORD_BYTES) begin
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = HOLD;
`ifdef ICACHE_EN
                        cache_we     = 1'b1;
`endif
                    end
                end
                HOLD: begin
                    if (consume) begin
                        pc_d         = pc_q + XLEN'(4);
                        inst_valid_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Redirect overrides everything, including a same-cycle consume
            if (bus.jump_en_in) begin
                pc_d         = bus.jump_addr_in & ~XLEN'(3);
                issue_cnt_d  = '0;
                recv_cnt_d   = '0;
                pending_d    = 1'b0;
                byte_held_d  = 1'b0;
                inst_valid_d = 1'b0;
                state_d      = IDLE;
`ifdef ICACHE_EN
                cache_we     = 1'b0;
`endif
            end

            mem_req_d  = (state_d == FETCH) && (issue_cnt_d != WORD_BYTES);
            mem_addr_d = pc_d + XLEN'(issue_cnt_d);
        end
    end

    // State and output registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            mem_addr_q     <= '0;
            inst_q         <= '0;
            inst_pc_q      <= '0;
            issue_cnt_q    <= '0;
            recv_cnt_q     <= '0;
            pending_q      <= 1'b0;
            pending_lane_q <= '0;
            byte_held_q    <= 1'b0;
            mem_req_q      <= 1'b0;
            inst_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            mem_addr_q     <= mem_addr_d;
            inst_q         <= inst_d;
            inst_pc_q      <= inst_pc_d;
            issue_cnt_q    <= issue_cnt_d;
            recv_cnt_q     <= recv_cnt_d;
            pending_q      <= pending_d;
            pending_lane_q <= pending_lane_d;
            byte_held_q    <= byte_held_d;
            mem_req_q      <= mem_req_d;
            inst_valid_q   <= inst_valid_d;
        end
    end

    // Request is suppressed immediately while the block is frozen
    assign bus.mem_req_out    = mem_req_q & bus.rdy_in;
    assign bus.mem_addr_out   = mem_addr_q;
    assign bus.inst_valid_out = inst_valid_q;
    assign bus.inst_out       = inst_q;
    assign bus.inst_pc_out    = inst_pc_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: byte memory model, directed scenarios, then
// randomized control with a scoreboard of expected instruction addresses.
module tb_fetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk_in = 1'b0;
    logic rst_in;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_pc;

    fetch_ctrl_if bus();

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Memory contents: fixed values at 0..3, a scrambled function of address elsewhere
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'd0) return 8'h13;
        if (a < 32'd4)  return 8'h00;
        h = a * 32'h9E37_79B1;
        return h[31:24] ^ a[7:0];
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: a byte granted in one cycle is presented during the next
    logic        g_rec;
    logic [31:0] a_rec;
    initial begin
        bus.mem_din_in = 8'h00;
        forever begin
            @(negedge clk_in);
            g_rec = bus.mem_req_out && bus.mem_grant_in;
            a_rec = bus.mem_addr_out;
            @(posedge clk_in);
            #1;
            bus.mem_din_in = g_rec ? mem_byte(a_rec) : 8'($urandom);
        end
    end

    // Monitor: compare presented instructions and requests against the scoreboard
    int idle_cyc = 0;
    initial begin
        logic [31:0] off;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                if (bus.inst_valid_out && !bus.jump_en_in) begin
                    idle_cyc = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_empty: got pc %h expected none", bus.inst_pc_out);
                    end else begin
                        check("inst_pc", bus.inst_pc_out, exp_q[0]);
                        check("inst_word", bus.inst_out, exp_word(exp_q[0]));
                        if (bus.rdy_in && !bus.stall_in) void'(exp_q.pop_front());
                    end
                end else begin
                    idle_cyc++;
                end
                if (bus.mem_req_out && !bus.jump_en_in && exp_q.size() != 0) begin
                    off = bus.mem_addr_out - exp_q[0];
                    check("req_addr_in_word", 32'(off < 32'd4), 32'd1);
                    check("req_while_valid", 32'(bus.inst_valid_out), 32'd0);
                end
                if (idle_cyc > 400) begin
                    checks++;
                    errors++;
                    $display("FAIL watchdog: got %0d idle cycles expected at most 400", idle_cyc);
                    idle_cyc = 0;
                end
            end
        end
    end

    // Drive one cycle of inputs, update the reference model, advance to next cycle
    task automatic step(input logic rdy, input logic stall, input logic jump,
                        input logic [31:0] jaddr, input logic grant);
        bus.rdy_in       = rdy;
        bus.stall_in     = stall;
        bus.jump_en_in   = jump;
        bus.jump_addr_in = jaddr;
        bus.mem_grant_in = grant;
        if (rdy && jump) begin
            exp_q.delete();
            m_pc = {jaddr[31:2], 2'b00};
            exp_q.push_back(m_pc);
        end else if (rdy && !stall && bus.inst_valid_out) begin
            m_pc = m_pc + 32'd4;
            exp_q.push_back(m_pc);
        end
        @(posedge clk_in);
        #2;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc = RESET_PC;
        exp_q.push_back(m_pc);
    endtask

    initial begin
        int n;
        int ngr;
        logic [31:0] hold_inst;
        logic [31:0] hold_pc;
        logic r, s, j, g;
        logic [31:0] ja;

        bus.rdy_in = 1'b1;
        bus.stall_in = 1'b1;
        bus.jump_en_in = 1'b0;
        bus.jump_addr_in = '0;
        bus.mem_grant_in = 1'b1;
        rst_in = 1'b1;
        model_reset();
        #1 rst_in = 1'b0;
        #22;
        check("rst_req", 32'(bus.mem_req_out), 32'd0);
        check("rst_addr", bus.mem_addr_out, 32'd0);
        check("rst_valid", 32'(bus.inst_valid_out), 32'd0);
        check("rst_inst", bus.inst_out, 32'd0);
        check("rst_inst_pc", bus.inst_pc_out, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // First fetch with continuous grant: valid 5 cycles after leaving IDLE
        n = 0;
        while (!bus.mem_req_out && n < 20) begin step(1, 1, 0, 0, 1); n++; end
        check("first_req_addr", bus.mem_addr_out, RESET_PC);
        n = 0;
        while (!bus.inst_valid_out && n < 20) begin step(1, 1, 0, 0, 1); n++; end
        check("first_latency", 32'(n), 32'd5);
        check("first_inst", bus.inst_out, 32'h0000_0013);
        check("first_inst_pc", bus.inst_pc_out, 32'h0);

        // Stall while valid: outputs hold and no memory traffic
        hold_inst = bus.inst_out;
        hold_pc   = bus.inst_pc_out;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 1);
            check("stall_inst", bus.inst_out, hold_inst);
            check("stall_pc", bus.inst_pc_out, hold_pc);
            check("stall_req", 32'(bus.mem_req_out), 32'd0);
        end
        step(1, 0, 0, 0, 1);
        n = 0;
        while (!bus.mem_req_out && n < 20) begin step(1, 1, 0, 0, 1); n++; end
        check("next_fetch_addr", bus.mem_addr_out, 32'd4);

        // Redirect to 0x1003 with two bytes issued
        n = 0;
        while (!(bus.mem_req_out && bus.mem_addr_out == 32'd6) && n < 20) begin
            step(1, 1, 0, 0, 1);
            n++;
        end
        check("jump_at_issue2", bus.mem_addr_out, 32'd6);
        step(1, 1, 1, 32'h0000_1003, 1);
        check("jump_valid_low", 32'(bus.inst_valid_out), 32'd0);
        n = 0;
        while (!bus.mem_req_out && n < 20) begin step(1, 1, 0, 0, 1); n++; end
        check("jump_fetch_addr", bus.mem_addr_out, 32'h0000_1000);

        // Alternating grant: word valid only after exactly four granted bytes
        ngr = 0;
        g = 1'b1;
        n = 0;
        while (!bus.inst_valid_out && n < 40) begin
            if (bus.mem_req_out && g) ngr++;
            step(1, 1, 0, 0, g);
            g = ~g;
            n++;
        end
        check("alt_grant_count", 32'(ngr), 32'd4);
        check("alt_grant_pc", bus.inst_pc_out, 32'h0000_1000);
        step(1, 0, 0, 0, 1);

        // Asynchronous reset in the middle of a fetch
        n = 0;
        while (!bus.mem_req_out && n < 20) begin step(1, 1, 0, 0, 1); n++; end
        step(1, 1, 0, 0, 1);
        rst_in = 1'b0;
        model_reset();
        #1;
        check("async_rst_req", 32'(bus.mem_req_out), 32'd0);
        check("async_rst_addr", bus.mem_addr_out, 32'd0);
        check("async_rst_valid", 32'(bus.inst_valid_out), 32'd0);
        check("async_rst_inst", bus.inst_out, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #2;

`ifdef ICACHE_EN
        // Cached loop: refetch of address 0 is a hit with no memory traffic
        n = 0;
        while (!bus.inst_valid_out && n < 30) begin step(1, 1, 0, 0, 1); n++; end
        step(1, 0, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            step(1, 1, 1, 32'h0, 1);
            check("cache_no_req_a", 32'(bus.mem_req_out), 32'd0);
            n = 0;
            while (!bus.inst_valid_out && n < 10) begin
                step(1, 1, 0, 0, 1);
                check("cache_no_req_b", 32'(bus.mem_req_out), 32'd0);
                n++;
            end
            check("cache_hit_latency", 32'(n), 32'd1);
            step(1, 0, 0, 0, 1);
        end
`endif

        // Randomized control, grants and redirects
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 9) != 0);
            s = 1'($urandom_range(0, 1));
            j = ($urandom_range(0, 49) == 0);
            g = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       ja = $urandom;
                1:       ja = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                2:       ja = 32'($urandom_range(0, 127));
                default: ja = m_pc + 32'($urandom_range(0, 63));
            endcase
            step(r, s, j, ja, g);
        end
        for (int i = 0; i < 40; i++) step(1, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
